// File: rtl/branch_redirect_pipem.sv
// Fetch-PC and redirect controller: owns the fetch PC, squashes younger stages
// after an accepted branch/jump, and produces the link write and a taken counter.
module branch_redirect_pipem #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStall,
  input  logic        iBranch,
  input  logic        iLink,
  input  logic        iJump,
  input  logic [31:0] iTarget,
  input  logic [31:0] iPCEx,
  output logic [31:0] oPC,
  output logic        oFlush,
  output logic        oLinkWe,
  output logic [31:0] oLinkData,
  output logic        oMisalign,
  output logic [15:0] oTakenCount
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;
  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  logic [0:0]  state_r;
  logic [0:0]  state_nxt_s;
  logic [1:0]  fcnt_r;
  logic [1:0]  fcnt_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] pc_inc_s;
  logic [15:0] taken_cnt_r;
  logic [15:0] taken_cnt_nxt_s;
  logic        accept_s;
  logic        link_s;
  logic [31:0] link_data_nxt_s;
  logic        link_we_r;
  logic [31:0] link_data_r;
  logic        misalign_r;
  logic        misalign_nxt_s;

  // Next-state, next-PC and counter decode for the RUN/FLUSH controller.
  always_comb begin
    accept_s        = 1'b0;
    state_nxt_s     = state_r;
    fcnt_nxt_s      = fcnt_r;
    pc_inc_s        = pc_r + 32'd4;
    pc_nxt_s        = pc_r;
    taken_cnt_nxt_s = taken_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (!iStall && (iBranch || iJump)) begin
          accept_s    = 1'b1;
          pc_nxt_s    = {iTarget[31:2], 2'b00};
          fcnt_nxt_s  = FCNT_INIT;
          state_nxt_s = ST_FLUSH;
          if (taken_cnt_r != 16'hFFFF) begin
            taken_cnt_nxt_s = taken_cnt_r + 16'd1;
          end else begin
            taken_cnt_nxt_s = taken_cnt_r;
          end
        end else if (!iStall) begin
          pc_nxt_s = pc_inc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_FLUSH: begin
        // Requests seen here belong to squashed instructions and are dropped.
        if (!iStall) begin
          pc_nxt_s = pc_inc_s;
          if (fcnt_r != 2'd0) begin
            fcnt_nxt_s = fcnt_r - 2'd1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        fcnt_nxt_s  = 2'd0;
      end
    endcase
  end

  // Link write and misalign pulse decode; both drop to zero on any stalled edge.
  always_comb begin
    link_s          = (state_r == ST_RUN) && !iStall && iLink;
    misalign_nxt_s  = accept_s && (iTarget[1:0] != 2'b00);
    link_data_nxt_s = link_data_r;
    if (link_s) begin
      link_data_nxt_s = iPCEx + 32'd4;
    end else begin
      link_data_nxt_s = link_data_r;
    end
  end

  // State, PC, counter and output registers with synchronous reset priority.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r     <= ST_RUN;
      fcnt_r      <= 2'd0;
      pc_r        <= RESET_PC;
      taken_cnt_r <= 16'd0;
      link_we_r   <= 1'b0;
      link_data_r <= 32'd0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fcnt_r      <= fcnt_nxt_s;
      pc_r        <= pc_nxt_s;
      taken_cnt_r <= taken_cnt_nxt_s;
      link_we_r   <= link_s;
      link_data_r <= link_data_nxt_s;
      misalign_r  <= misalign_nxt_s;
    end
  end

  assign oPC         = pc_r;
  assign oFlush      = (state_r == ST_FLUSH);
  assign oLinkWe     = link_we_r;
  assign oLinkData   = link_data_r;
  assign oMisalign   = misalign_r;
  assign oTakenCount = taken_cnt_r;

endmodule

// File: tb/tb_branch_redirect_pipem.sv
// Scoreboard bench for branch_redirect_pipem: a cycle-level reference model
// queues expected outputs; an independent monitor compares them each cycle.
module tb_branch_redirect_pipem;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          FLUSH_N  = 2;

  logic        iCLK = 1'b0;
  logic        iRST, iStall, iBranch, iLink, iJump;
  logic [31:0] iTarget, iPCEx;
  logic [31:0] oPC, oLinkData;
  logic        oFlush, oLinkWe, oMisalign;
  logic [15:0] oTakenCount;

  branch_redirect_pipem #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStall(iStall), .iBranch(iBranch),
    .iLink(iLink), .iJump(iJump), .iTarget(iTarget), .iPCEx(iPCEx),
    .oPC(oPC), .oFlush(oFlush), .oLinkWe(oLinkWe), .oLinkData(oLinkData),
    .oMisalign(oMisalign), .oTakenCount(oTakenCount)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        flush;
    logic        lwe;
    logic [31:0] ldata;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state: remaining flush cycles rather than an FSM.
  logic [31:0] m_pc;
  int          m_fl;
  logic [15:0] m_cnt;
  logic        m_lwe;
  logic [31:0] m_ldata;
  logic        m_mis;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, req);
    end
  endtask

  // Monitor: compares the DUT against the expectation queued for this cycle.
  always @(negedge iCLK) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("stale_expectation", 32'(e.cyc), 32'(cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("pc", oPC, e.pc);
      check("flush", 32'(oFlush), 32'(e.flush));
      check("link_we", 32'(oLinkWe), 32'(e.lwe));
      check("link_data", oLinkData, e.ldata);
      check("misalign", 32'(oMisalign), 32'(e.mis));
      check("taken_count", 32'(oTakenCount), 32'(e.cnt));
    end
  end

  task automatic step(input logic rst, input logic stall, input logic br, input logic lk,
                      input logic jp, input logic [31:0] tgt, input logic [31:0] pcex);
    exp_t e;
    iRST = rst; iStall = stall; iBranch = br; iLink = lk; iJump = jp;
    iTarget = tgt; iPCEx = pcex;
    if (rst) begin
      m_pc = RESET_PC; m_fl = 0; m_cnt = 16'd0; m_lwe = 1'b0; m_ldata = 32'd0; m_mis = 1'b0;
    end else if (stall) begin
      m_lwe = 1'b0; m_mis = 1'b0;
    end else if (m_fl > 0) begin
      m_pc = m_pc + 32'd4; m_fl = m_fl - 1; m_lwe = 1'b0; m_mis = 1'b0;
    end else begin
      m_lwe = lk;
      if (lk) m_ldata = pcex + 32'd4;
      if (br || jp) begin
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_mis = (tgt % 4) != 0;
        m_fl  = FLUSH_N;
        if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_mis = 1'b0;
      end
    end
    e.cyc = cyc + 1; e.pc = m_pc; e.flush = (m_fl > 0); e.lwe = m_lwe;
    e.ldata = m_ldata; e.mis = m_mis; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    iRST = 1'b1; iStall = 1'b0; iBranch = 1'b0; iLink = 1'b0; iJump = 1'b0;
    iTarget = 32'd0; iPCEx = 32'd0;
    m_pc = 32'd0; m_fl = 0; m_cnt = 16'd0; m_lwe = 1'b0; m_ldata = 32'd0; m_mis = 1'b0;

    // Reset and free-running fetch up to 0040_0010.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(4);
    // Taken branch.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0100, 32'h0040_000C);
    idle(3);
    // Branch-and-link not taken.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0999, 32'h0040_0020);
    idle(2);
    // Jump held under stall, then a stall inside FLUSH.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0030);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0030);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);
    // Requests during FLUSH are ignored; back-to-back request right after.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0400, 32'h0040_0040);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0300, 32'h0040_0044);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0300, 32'h0040_0048);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0800, 32'h0040_0404);
    idle(3);
    // Misaligned target.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0102, 32'h0040_0050);
    idle(3);
    // Counter saturation from a preloaded 16'hFFFF.
    @(negedge iCLK);
    #1;
    force dut.taken_cnt_r = 16'hFFFF;
    #1;
    release dut.taken_cnt_r;
    m_cnt = 16'hFFFF;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0500, 32'h0040_0060);
    idle(3);
    // Reset in the middle of FLUSH.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0600, 32'h0040_0070);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0700, 32'h0040_0074);
    idle(2);
    // PC wrap past 32'hFFFF_FFFC.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0040_0080);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
      step(($urandom_range(127, 0) == 0), ($urandom_range(3, 0) == 0),
           ($urandom_range(4, 0) == 0), ($urandom_range(4, 0) == 0),
           ($urandom_range(9, 0) == 0), t, $urandom);
    end

    iRST = 1'b0; iStall = 1'b0; iBranch = 1'b0; iLink = 1'b0; iJump = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_pipem.md
# branch_redirect_pipem

Fetch-PC and redirect controller for the pipelined core, directly downstream of the branch comparator. It consumes the taken and link decisions (`iBranch`, `iLink`) plus unconditional-jump requests, and owns the fetch PC register. On an accepted redirect it loads the target and squashes the younger pipeline stages for a fixed number of advancing cycles. It also produces the link-register write and a saturating taken-redirect counter.

## Interface
- `RESET_PC`, default 32'h0040_0000: fetch PC loaded on reset.
- `FLUSH_CYCLES`, default 2: number of advancing cycles `oFlush` is held after a redirect. Legal range 1..3.

Ports:
- `iCLK`  in  1  core clock; all state updates on the rising edge.
- `iRST`  in  1  synchronous, active-high reset.
- `iStall`  in  1  hazard-unit hold; freezes the PC and this block's state.
- `iBranch`  in  1  branch taken (from the branch comparator).
- `iLink`  in  1  branch-and-link / jal: write the return address.
- `iJump`  in  1  unconditional jump resolved this cycle.
- `iTarget`  in  32  redirect target computed in the resolving stage.
- `iPCEx`  in  32  PC of the instruction in the resolving stage.
- `oPC`  out  32  fetch PC (registered).
- `oFlush`  out  1  squash IF/ID and younger stage contents.
- `oLinkWe`  out  1  register-file write enable for the link register (one-cycle pulse).
- `oLinkData`  out  32  return address, iPCEx+4.
- `oMisalign`  out  1  one-cycle pulse: accepted target had bits[1:0] nonzero.
- `oTakenCount`  out  16  count of accepted redirects, saturating at 16'hFFFF.

## Operation
- Two-state FSM: RUN and FLUSH, plus a 2-bit flush counter `fcnt`.
- **Accept** = RUN & !iStall & (iBranch | iJump).
- **RUN state:**
  - On accept:
    - oPC <= {iTarget[31:2], 2'b00}.
    - oMisalign <= |iTarget[1:0].
    - oTakenCount increments, holding at 16'hFFFF.
    - fcnt <= FLUSH_CYCLES-1; state <= FLUSH.
  - Otherwise, when !iStall: oPC <= oPC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- **Both asserted:** iBranch and iJump together count as one redirect to iTarget.
- **Link write:**
  - In RUN with !iStall and iLink=1, the next cycle has oLinkWe=1 and oLinkData=iPCEx+4.
  - This happens regardless of iBranch, because bgezal/bltzal link even when not taken.
  - Otherwise oLinkWe=0 and oLinkData holds its last value.
- **FLUSH state:**
  - oFlush=1.
  - iBranch, iJump and iLink are ignored; they belong to squashed instructions.
  - When !iStall: oPC <= oPC+4.
  - When !iStall and fcnt!=0: fcnt decrements.
  - When !iStall and fcnt==0: state <= RUN.
- **oFlush** = (state==FLUSH). It is a registered decode with no combinational path from the inputs.
- **Stall in either state:** oPC, state, fcnt and oTakenCount hold, and no redirect is accepted. The resolving stage re-presents its request after the stall.
- **Outputs while stalled:** oLinkWe and oMisalign are forced to 0, so their pulses are never stretched.
- **Reset:** iRST has priority over all other inputs in any state, including mid-FLUSH.

## Timing
- Reset values:
  - oPC=RESET_PC
  - oFlush=0
  - oLinkWe=0
  - oLinkData=0
  - oMisalign=0
  - oTakenCount=0
  - state=RUN, fcnt=0
- **Redirect latency:** request accepted at edge N gives oPC=target and oFlush=1 from cycle N+1.
- **Flush duration:** oFlush stays high for exactly FLUSH_CYCLES non-stalled cycles. Stalled cycles inside FLUSH extend it.
- **Back-to-back requests:** a redirect request in the first RUN cycle after FLUSH is accepted normally.
- **Link:** oLinkWe is a pulse one cycle after acceptance, aligned with oFlush's first cycle.
- **Misalign:** oMisalign is aligned with oPC=target.

## Test plan
1. **Reset:** iRST=1 for 2 cycles, then release with no requests. Required: oPC=32'h0040_0000, then 0040_0004, 0040_0008; oFlush=0.
2. **Taken branch:** at PC 0040_0010, assert iBranch=1, iTarget=0040_0100. Required:
   - next cycle oPC=0040_0100 and oFlush=1 for 2 cycles, then 0;
   - oPC reaches 0040_0108 with oFlush=0;
   - oTakenCount=1.
3. **Branch-and-link not taken:** iLink=1, iBranch=0, iPCEx=0040_0020. Required: oLinkWe pulse with oLinkData=0040_0024, no flush, oPC continues +4.
4. **Stall interaction:** iStall=1 together with iJump=1, iTarget=0040_0200 for 3 cycles, then iStall=0. Required:
   - oPC frozen while stalled;
   - oPC=0040_0200 one cycle after release;
   - a stall during FLUSH stretches oFlush by the number of stalled cycles.
5. **Ignored requests in FLUSH:** iBranch=1 with iTarget=0040_0300 during FLUSH. Required: ignored; oPC follows old target +4; oTakenCount is unchanged.
6. **Edge cases:**
   - iTarget=0040_0102 gives oPC=0040_0100 and an oMisalign pulse.
   - Preloading oTakenCount to 16'hFFFF and taking a branch keeps it at 16'hFFFF.
   - iRST mid-FLUSH returns oPC=RESET_PC and oFlush=0 the next cycle.
